// File: rtl/atm_input_pkg.sv
// Shared types and default constants for the keypad input debouncer.
package atm_input_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    localparam int DB_STABLE_TICKS = 3;
    localparam int DB_REPEAT_DELAY = 10;
    localparam int DB_REPEAT_RATE  = 5;

    // Largest of three values; used to check counter width against the timing constants.
    function automatic int db_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: tick-qualified debounce FSM with level and press-pulse outputs.
// Optional build macro AUTO_REPEAT_EN adds held-key auto-repeat pulses.
//
//   state        | meaning
//   -------------+-----------------------------------------------
//   IDLE         | button released and stable
//   PRESS_WAIT   | seen pressed, counting agreeing ticks
//   PRESSED      | press accepted, level high
//   RELEASE_WAIT | seen released, counting agreeing ticks
module debounce_channel
    import atm_input_pkg::*;
#(
    parameter int STABLE_TICKS = DB_STABLE_TICKS,
    parameter int CNT_W        = 4
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = DB_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DB_REPEAT_RATE
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic samp,
    output logic level,
    output logic pulse
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_TICKS);

    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_DELAY_C = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_RATE_C  = CNT_W'(REPEAT_RATE);

    // rep_run_q selects the inter-repeat period once the first repeat has fired,
    // so the counter only ever has to reach max(delay, rate) and never wraps.
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_run_q, rep_run_d;
`endif

    // Next-state logic; everything advances only on a sample tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_cnt_d = rep_cnt_q;
        rep_run_d = rep_run_q;
`endif
        if (tick) begin
`ifdef AUTO_REPEAT_EN
            if (state_q == PRESSED || state_q == RELEASE_WAIT) begin
                rep_cnt_d = rep_cnt_q + 1'b1;
                if (rep_cnt_d == (rep_run_q ? REP_RATE_C : REP_DELAY_C)) begin
                    pulse_d   = 1'b1;
                    rep_cnt_d = '0;
                    rep_run_d = 1'b1;
                end
            end
`endif
            unique case (state_q)
                IDLE: begin
                    if (samp) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = PRESSED;
                            level_d = 1'b1;
                            pulse_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = PRESS_WAIT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!samp) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if ((cnt_q + 1'b1) == STABLE_LAST) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!samp) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = IDLE;
                            level_d = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            state_d = RELEASE_WAIT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (samp) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if ((cnt_q + 1'b1) == STABLE_LAST) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    level_d = 1'b0;
                    cnt_d   = '0;
                end
            endcase
`ifdef AUTO_REPEAT_EN
            // A release completing on the same tick as a repeat must not emit a pulse.
            if (state_d == IDLE) begin
                pulse_d   = 1'b0;
                rep_cnt_d = '0;
                rep_run_d = 1'b0;
            end
            if (state_q == PRESS_WAIT && state_d == PRESSED) begin
                rep_cnt_d = '0;
                rep_run_d = 1'b0;
            end
`endif
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q <= '0;
            rep_run_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q <= rep_cnt_d;
            rep_run_q <= rep_run_d;
`endif
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Keypad debouncer top: s_clk rising-edge tick generator, button synchronisers
// and one debounce_channel per button. Optional build macro AUTO_REPEAT_EN.
module btn_debounce_pulse
    import atm_input_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int STABLE_TICKS = DB_STABLE_TICKS,
    parameter int CNT_W        = 4,
    parameter int REPEAT_DELAY = DB_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DB_REPEAT_RATE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_clk,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    if (STABLE_TICKS < 1 || STABLE_TICKS > 15 ||
        (2 ** CNT_W) <= db_max3(STABLE_TICKS, REPEAT_DELAY, REPEAT_RATE)) begin : g_cfg_err
        $error("btn_debounce_pulse: CNT_W too narrow or STABLE_TICKS out of 1..15");
    end

    logic [1:0]       s_sync_q, s_sync_d;
    logic             s_dly_q, s_dly_d;
    logic [N_BTN-1:0] btn_sync1_q, btn_sync1_d;
    logic [N_BTN-1:0] btn_sync2_q, btn_sync2_d;
    logic             tick;

    // Synchroniser shift paths; s_clk is only ever sampled as data.
    always_comb begin
        s_sync_d    = {s_sync_q[0], s_clk};
        s_dly_d     = s_sync_q[1];
        btn_sync1_d = btn_raw;
        btn_sync2_d = btn_sync1_q;
    end

    // Synchroniser and edge-detect delay flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_sync_q    <= '0;
            s_dly_q     <= 1'b0;
            btn_sync1_q <= '0;
            btn_sync2_q <= '0;
        end else begin
            s_sync_q    <= s_sync_d;
            s_dly_q     <= s_dly_d;
            btn_sync1_q <= btn_sync1_d;
            btn_sync2_q <= btn_sync2_d;
        end
    end

    assign tick = s_sync_q[1] & ~s_dly_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS),
            .CNT_W       (CNT_W)
`ifdef AUTO_REPEAT_EN
            ,
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
`endif
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .samp (btn_sync2_q[i]),
            .level(btn_level[i]),
            .pulse(btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse (STABLE_TICKS=3, REPEAT_DELAY=10, REPEAT_RATE=5).
module tb_btn_debounce_pulse;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_clk;
    logic [3:0] btn_raw;
    wire  [3:0] btn_level;
    wire  [3:0] btn_pulse;

    int         n_vec  = 0;
    int         n_fail = 0;
    int         pcnt [4];
    logic [3:0] lvl_at, pls_at, pls_pre;
    logic [24:0] rep_mask, rep_exp;
    int          rep_total;
    logic        pat [5];
    logic        lvl_exp [5];

    always #5 clk = ~clk;

    btn_debounce_pulse #(
        .N_BTN(4), .STABLE_TICKS(3), .CNT_W(4), .REPEAT_DELAY(10), .REPEAT_RATE(5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_clk    (s_clk),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_pcnt();
        for (int b = 0; b < 4; b++) pcnt[b] = 0;
    endtask

    // One s_clk period (4 high, 4 low clk). The FSMs act on the 3rd edge after the rise.
    task automatic tick_with(input logic [3:0] raw);
        btn_raw = raw;
        s_clk   = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) pls_pre = btn_pulse;
            if (c == 3) begin
                lvl_at = btn_level;
                pls_at = btn_pulse;
            end
            for (int b = 0; b < 4; b++) pcnt[b] += int'(btn_pulse[b]);
            if (c == 4) s_clk = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with buttons pressed and s_clk toggling
        rst_n   = 1'b0;
        s_clk   = 1'b0;
        btn_raw = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            s_clk = ~s_clk;
            if (i == 2 || i == 5) begin
                check("rst_level", btn_level, 4'h0);
                check("rst_pulse", btn_pulse, 4'h0);
            end
        end
        s_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_level", btn_level, 4'h0);
        clr_pcnt();
        tick_with(4'hF);
        check("rst_t1_level", lvl_at, 4'h0);
        tick_with(4'hF);
        check("rst_t2_level", lvl_at, 4'h0);
        tick_with(4'hF);
        check("rst_t3_level", lvl_at, 4'hF);
        check("rst_t3_pulse", pls_at, 4'hF);
        check("rst_t3_prepulse", pls_pre, 4'h0);
        tick_with(4'hF);
        tick_with(4'hF);
        for (int b = 0; b < 4; b++) check("rst_pulse_count", pcnt[b], 1);
        tick_with(4'h0);
        tick_with(4'h0);
        check("rst_rel_t2_level", lvl_at, 4'hF);
        tick_with(4'h0);
        check("rst_rel_t3_level", lvl_at, 4'h0);

        // Clean press on button 0
        clr_pcnt();
        tick_with(4'b0001);
        check("press_t1_level", lvl_at, 4'h0);
        tick_with(4'b0001);
        tick_with(4'b0001);
        check("press_t3_level", lvl_at, 4'b0001);
        check("press_t3_pulse", pls_at, 4'b0001);
        check("press_prepulse", pls_pre, 4'h0);
        check("press_pulse_count", pcnt[0], 1);
        repeat (3) tick_with(4'h0);
        check("press_rel_level", lvl_at, 4'h0);

        // Bounce rejection on button 1
        clr_pcnt();
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            tick_with({2'b00, pat[k], 1'b0});
            check("bounce_level", lvl_at[1], 1'b0);
        end
        check("bounce_pulse_count", pcnt[1], 0);
        repeat (2) tick_with(4'h0);

        // Release debounce on button 2
        repeat (3) tick_with(4'b0100);
        check("rel_setup_level", lvl_at, 4'b0100);
        clr_pcnt();
        pat     = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        lvl_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            tick_with({1'b0, pat[k], 2'b00});
            check("rel_level", lvl_at[2], lvl_exp[k]);
        end
        check("rel_pulse_count", pcnt[2], 0);

        // Simultaneous press on buttons 0 and 3
        clr_pcnt();
        repeat (3) tick_with(4'b1001);
        check("simul_pulse", pls_at, 4'b1001);
        check("simul_level", lvl_at, 4'b1001);
        check("simul_cnt0", pcnt[0], 1);
        check("simul_cnt3", pcnt[3], 1);
        repeat (3) tick_with(4'h0);
        check("simul_rel_level", lvl_at, 4'h0);

        // Reset during PRESS_WAIT with cnt = 2
        clr_pcnt();
        tick_with(4'b0001);
        tick_with(4'b0001);
        check("midrst_pre_level", lvl_at, 4'h0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_level", btn_level, 4'h0);
        check("midrst_pulse", btn_pulse, 4'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tick_with(4'b0001);
        check("midrst_t1_pulse", pls_at, 4'h0);
        check("midrst_t1_level", lvl_at, 4'h0);
        tick_with(4'b0001);
        tick_with(4'b0001);
        check("midrst_t3_pulse", pls_at, 4'b0001);
        check("midrst_pulse_count", pcnt[0], 1);
        repeat (3) tick_with(4'h0);

        // Long hold on button 0: auto-repeat behaviour depends on the build
        clr_pcnt();
        rep_mask = '0;
        for (int k = 0; k < 25; k++) begin
            tick_with(4'b0001);
            rep_mask[k] = pls_at[0];
        end
`ifdef AUTO_REPEAT_EN
        rep_exp   = 25'h0421004;
        rep_total = 4;
`else
        rep_exp   = 25'h0000004;
        rep_total = 1;
`endif
        check("hold_pulse_ticks", rep_mask, rep_exp);
        check("hold_pulse_count", pcnt[0], rep_total);
        repeat (3) tick_with(4'h0);
        check("hold_rel_level", lvl_at, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
